// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: FIFO controller for an external two-port memory.
// Read data comes from the memory's registered output, so popData is
// valid exactly one cycle after an accepted pop (flagged by popValid).
// Optional build macro MEM_FIFO_ERR_FLAGS_EN adds sticky overflow and
// underflow outputs.
module mem_fifo_ctrl #(
  parameter  int addresses       = 32,
  parameter  int width           = 8,
  parameter  int almostFullLevel = 28,
  localparam int addressWidth    = $clog2(addresses),
  localparam int countWidth      = $clog2(addresses + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [width-1:0]        pushData,
  output logic                    full,
  output logic                    almostFull,
  input  logic                    pop,
  output logic [width-1:0]        popData,
  output logic                    popValid,
  output logic                    empty,
  output logic [countWidth-1:0]   count,
  output logic [addressWidth-1:0] memWriteAddress,
  output logic                    memWriteEnable,
  output logic [width-1:0]        memWriteData,
  output logic [addressWidth-1:0] memReadAddress,
  output logic                    memReadEnable,
  input  logic [width-1:0]        memReadData
`ifdef MEM_FIFO_ERR_FLAGS_EN
  ,
  output logic                    overflow,
  output logic                    underflow
`endif
);

  localparam logic [addressWidth-1:0] ADDR_LAST = addressWidth'(addresses - 1);
  localparam logic [countWidth-1:0]   COUNT_MAX = countWidth'(addresses);

  logic [addressWidth-1:0] wrPtr_q, wrPtr_d;
  logic [addressWidth-1:0] rdPtr_q, rdPtr_d;
  logic [countWidth-1:0]   count_q, count_d;
  logic                    full_q, full_d;
  logic                    empty_q, empty_d;
  logic                    almostFull_q, almostFull_d;
  logic                    popValid_q, popValid_d;
  logic                    pushAcc, popAcc;

  // Accept decisions use the registered flags; reset blocks all memory access.
  always_comb begin
    pushAcc = push && !full_q && !reset;
    popAcc  = pop && !empty_q && !reset;
  end

  // Pointer, occupancy and flag next-state.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushAcc) begin
      wrPtr_d = (wrPtr_q == ADDR_LAST) ? '0 : wrPtr_q + 1'b1;
    end
    if (popAcc) begin
      rdPtr_d = (rdPtr_q == ADDR_LAST) ? '0 : rdPtr_q + 1'b1;
    end
    case ({pushAcc, popAcc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d       = (count_d == COUNT_MAX);
    empty_d      = (count_d == '0);
    almostFull_d = (32'(count_d) >= almostFullLevel);
    popValid_d   = popAcc;
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      almostFull_q <= 1'b0;
      popValid_q   <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      almostFull_q <= almostFull_d;
      popValid_q   <= popValid_d;
    end
  end

`ifdef MEM_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: only reset clears them.
  always_comb begin
    overflow_d  = overflow_q | (push && full_q);
    underflow_d = underflow_q | (pop && empty_q);
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  // Output mapping; same-cycle read and write can never collide, so no bypass.
  always_comb begin
    full            = full_q;
    empty           = empty_q;
    almostFull      = almostFull_q;
    count           = count_q;
    popValid        = popValid_q;
    popData         = memReadData;
    memWriteEnable  = pushAcc;
    memWriteAddress = wrPtr_q;
    memWriteData    = pushData;
    memReadEnable   = popAcc;
    memReadAddress  = rdPtr_q;
  end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl (addresses=5) with a queue-based
// reference model, a behavioural two-port memory and directed plus
// randomized stimulus.
module tb_mem_fifo_ctrl;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int AF = 4;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [W-1:0]  pushData = '0;
  logic          full, almostFull, popValid, empty;
  logic [W-1:0]  popData;
  logic [CW-1:0] count;
  logic [AW-1:0] memWriteAddress, memReadAddress;
  logic          memWriteEnable, memReadEnable;
  logic [W-1:0]  memWriteData;
  logic [W-1:0]  memReadData = '0;
`ifdef MEM_FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
  bit            exp_ov, exp_un;
`endif

  mem_fifo_ctrl #(.addresses(N), .width(W), .almostFullLevel(AF)) dut (
    .clk(clk), .reset(reset), .push(push), .pushData(pushData),
    .full(full), .almostFull(almostFull), .pop(pop), .popData(popData),
    .popValid(popValid), .empty(empty), .count(count),
    .memWriteAddress(memWriteAddress), .memWriteEnable(memWriteEnable),
    .memWriteData(memWriteData), .memReadAddress(memReadAddress),
    .memReadEnable(memReadEnable), .memReadData(memReadData)
`ifdef MEM_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural two-port memory with registered read data.
  logic [W-1:0] mem [N];
  always @(posedge clk) begin
    if (memWriteEnable) mem[memWriteAddress] <= memWriteData;
    if (memReadEnable) memReadData <= mem[memReadAddress];
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [W-1:0] q[$];
  int           wp, rp;
  bit           exp_pv;
  logic [W-1:0] exp_pd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    wp = 0;
    rp = 0;
    exp_pv = 1'b0;
    exp_pd = '0;
`ifdef MEM_FIFO_ERR_FLAGS_EN
    exp_ov = 1'b0;
    exp_un = 1'b0;
`endif
  endtask

  // Compares every output against the model for the current cycle.
  task automatic compare();
    int n = q.size();
    chk("count", 32'(count), n);
    chk("full", 32'(full), 32'(n == N));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almostFull", 32'(almostFull), 32'(n >= AF));
    chk("popValid", 32'(popValid), 32'(exp_pv));
    if (exp_pv) chk("popData", 32'(popData), 32'(exp_pd));
    chk("memWriteEnable", 32'(memWriteEnable), 32'(push && n < N));
    chk("memReadEnable", 32'(memReadEnable), 32'(pop && n > 0));
    if (push && n < N) begin
      chk("memWriteAddress", 32'(memWriteAddress), wp);
      chk("memWriteData", 32'(memWriteData), 32'(pushData));
    end
    if (pop && n > 0) chk("memReadAddress", 32'(memReadAddress), rp);
`ifdef MEM_FIFO_ERR_FLAGS_EN
    chk("overflow", 32'(overflow), 32'(exp_ov));
    chk("underflow", 32'(underflow), 32'(exp_un));
`endif
  endtask

  // Advances the model by one clock edge with the current inputs.
  task automatic update();
    int n = q.size();
    bit pa = push && (n < N);
    bit oa = pop && (n > 0);
`ifdef MEM_FIFO_ERR_FLAGS_EN
    exp_ov = exp_ov | (push && n == N);
    exp_un = exp_un | (pop && n == 0);
`endif
    exp_pv = oa;
    if (oa) begin
      exp_pd = q.pop_front();
      rp = (rp + 1) % N;
    end
    if (pa) begin
      q.push_back(pushData);
      wp = (wp + 1) % N;
    end
  endtask

  task automatic step(input bit p, input bit o, input logic [W-1:0] d);
    @(negedge clk);
    push = p;
    pop = o;
    pushData = d;
    #1;
    compare();
    update();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pp;
    model_reset();
    #2;
    reset = 1'b1;
    push = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_almostFull", 32'(almostFull), 0);
    chk("rst_popValid", 32'(popValid), 0);
    chk("rst_memWriteEnable", 32'(memWriteEnable), 0);
    push = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Fill to full; the sixth push must not write.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h11 + i));
    step(1'b1, 1'b0, 8'h16);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 5);
    chk("fill_6th_no_write", 32'(memWriteEnable), 0);
    chk("fill_almostFull", 32'(almostFull), 1);

    // Drain; data appears one cycle after each pop.
    step(1'b0, 1'b1, 8'h00);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("drain_popData", 32'(popData), 32'(8'h11 + i - 1));
      chk("drain_popValid", 32'(popValid), 1);
    end
    step(1'b0, 1'b0, 8'h00);
    chk("drain_last_popData", 32'(popData), 32'h15);
    chk("drain_empty", 32'(empty), 1);

    // Write address wraps 0..4,0.. while streaming.
    step(1'b1, 1'b0, 8'h20);
    chk("wrap_addr0", 32'(memWriteAddress), 0);
    for (int i = 1; i < 12; i++) begin
      step(1'b1, 1'b1, 8'(8'h20 + i));
      chk("wrap_addr", 32'(memWriteAddress), i % 5);
    end
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("wrap_last_popData", 32'(popData), 32'h2b);

    // Simultaneous push+pop when empty, full, and count=2.
    step(1'b1, 1'b1, 8'h40);
    step(1'b0, 1'b0, 8'h00);
    chk("pp_empty_count", 32'(count), 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h41 + i));
    step(1'b1, 1'b1, 8'h50);
    step(1'b0, 1'b0, 8'h00);
    chk("pp_full_count", 32'(count), 4);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h60);
    chk("pp_mid_before", 32'(count), 2);
    step(1'b0, 1'b0, 8'h00);
    chk("pp_mid_count", 32'(count), 2);

    // Randomized phases alternating fill-biased and drain-biased traffic.
    for (int k = 0; k < 600; k++) begin
      pp = ((k / 100) % 2 == 1) ? 70 : 30;
      step($urandom_range(99) < pp, $urandom_range(99) < (100 - pp), 8'($urandom));
    end

    // Asynchronous reset with three entries stored.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
    step(1'b0, 1'b0, 8'h00);
    chk("prerst_count", 32'(count), 3);
    #2;
    reset = 1'b1;
    push = 1'b1;
    pop = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_empty", 32'(empty), 1);
    chk("async_rst_full", 32'(full), 0);
    chk("async_rst_popValid", 32'(popValid), 0);
    chk("async_rst_we", 32'(memWriteEnable), 0);
    chk("async_rst_re", 32'(memReadEnable), 0);
`ifdef MEM_FIFO_ERR_FLAGS_EN
    chk("async_rst_overflow", 32'(overflow), 0);
    chk("async_rst_underflow", 32'(underflow), 0);
`endif
    model_reset();
    push = 1'b0;
    pop = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b1, 8'h00);
    chk("postrst_pop_ignored", 32'(memReadEnable), 0);
    step(1'b0, 1'b0, 8'h00);
    chk("postrst_popValid", 32'(popValid), 0);
`ifdef MEM_FIFO_ERR_FLAGS_EN
    chk("underflow_set", 32'(underflow), 1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    step(1'b0, 1'b0, 8'h00);
    chk("overflow_set", 32'(overflow), 1);
    chk("underflow_held", 32'(underflow), 1);
`endif
    step(1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mem_fifo_ctrl.md
MEM_FIFO_CTRL -- requirements
Module: mem_fifo_ctrl

Interface
REQ-001 Parameter addresses, default 32: FIFO depth (entries); any value >=2, power of two not required.
REQ-002 Parameter width, default 8: data word width.
REQ-003 Parameter almostFullLevel, default 28: almostFull asserts when count >= almostFullLevel.
REQ-004 Localparams: addressWidth = clogb2(addresses); countWidth = clogb2(addresses+1).
REQ-005 clk  input  1  single clock for all logic and for the attached two-port memory (both memory clocks tied to clk).
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 push  input  1  write request.
REQ-008 pushData  input  width  write data.
REQ-009 full  output  1  no free entry.
REQ-010 almostFull  output  1  count >= almostFullLevel.
REQ-011 pop  input  1  read request.
REQ-012 popData  output  width  read data; direct pass-through of memReadData.
REQ-013 popValid  output  1  popData holds the word of the pop accepted in the previous cycle.
REQ-014 empty  output  1  no stored entry.
REQ-015 count  output  countWidth  stored entries.
REQ-016 memWriteAddress / memWriteEnable / memWriteData  output  addressWidth / 1 / width  memory write port.
REQ-017 memReadAddress / memReadEnable  output  addressWidth / 1  memory read port.
REQ-018 memReadData  input  width  memory read data, registered in memory, valid one cycle after memReadEnable.

Function
REQ-019 Push accepted = push && !full; pop accepted = pop && !empty; full/empty are registered state from the start of the cycle.
REQ-020 memWriteEnable = push accepted (combinational); memWriteAddress = wrPtr; memWriteData = pushData.
REQ-021 memReadEnable = pop accepted (combinational); memReadAddress = rdPtr.
REQ-022 wrPtr increments on accepted push, rdPtr on accepted pop; each wraps from addresses-1 to 0.
REQ-023 count: +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds addresses or goes below 0.
REQ-024 full = (count==addresses), empty = (count==0), almostFull per REQ-003; all registered, updated on the same edge as count.
REQ-025 popValid registered: equals pop-accepted of previous cycle; read latency pop->popData is exactly 1 cycle.
REQ-026 Push while full: ignored, no memory write, no state change (except REQ-035 flag).
REQ-027 Pop while empty: ignored, no memory read, popValid 0 next cycle (except REQ-035 flag).
REQ-028 Push+pop while full: pop accepted, push rejected; count becomes addresses-1.
REQ-029 Push+pop while empty: push accepted, pop rejected (no fall-through); count becomes 1.
REQ-030 Push+pop otherwise: both accepted, count unchanged, both pointers advance.
REQ-031 Write and read in the same cycle never target the same address (guaranteed by REQ-019); no bypass logic.

Reset
REQ-032 On reset assertion, immediately: wrPtr=0, rdPtr=0, count=0, empty=1, full=0, almostFull=0, popValid=0, error flags=0.
REQ-033 Reset mid-operation discards all entries; memory contents are not cleared; memWriteEnable/memReadEnable are 0 while reset is high.
REQ-034 Release of reset is synchronous to clk by the integrator; first accepted operation is on the first edge after release.

Configuration
REQ-035 Macro MEM_FIFO_ERR_FLAGS_EN defined: outputs overflow and underflow (1 bit each) exist; sticky, set on push-while-full / pop-while-empty, cleared only by reset.
REQ-036 Macro undefined: overflow/underflow ports and logic are absent; all other behaviour identical.

Verification
REQ-037 addresses=5: push 5 words 0x11..0x15 -> full=1 after 5th edge, count=5; 6th push gives no memWriteEnable.
REQ-038 Pop 5 times from REQ-037 state -> popData 0x11..0x15 each one cycle after pop with popValid=1; empty=1 after 5th pop.
REQ-039 addresses=5: 12 pushes interleaved with pops -> memWriteAddress sequence 0,1,2,3,4,0,1,...; data order preserved.
REQ-040 Simultaneous push+pop when empty, full, and count=2 -> count 1, 4, 2 respectively per REQ-028..030.
REQ-041 Assert reset with count=3 mid-stream -> all outputs at REQ-032 values without a clock edge; next pop ignored.
REQ-042 With MEM_FIFO_ERR_FLAGS_EN: pop when empty then push when full -> underflow then overflow set and held until reset.
